// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with a registered result and zero/overflow flags.
// Operand a is zero-extended to WIDTH; all arithmetic is unsigned and wraps
// modulo 2^WIDTH.
//
// Build option: define ALU_PIPE_MUL_EN to make op 110 an iterative
// shift-add multiplier that takes WIDTH cycles. Without it, op 110 is a
// single-cycle op that returns zero.
module alu_pipe #(
    parameter int WIDTH   = 32,
    parameter int A_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   ans,
    output logic               zero,
    output logic               ovf,
    output logic               busy
);

    localparam int SH_W = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_SHL = 3'b111;

    logic [WIDTH-1:0] ax;
    assign ax = WIDTH'(a);

    // Output register
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] ans_q, ans_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic accept;
    logic load_alu;

    // Single-cycle datapath result and its overflow flag
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] res_alu;
    logic             ovf_alu;

    // Combinational single-cycle ALU; the borrow is the top bit of the extended difference
    always_comb begin
        sum_w   = {1'b0, ax} + {1'b0, b};
        diff_w  = {1'b0, ax} - {1'b0, b};
        res_alu = '0;
        ovf_alu = 1'b0;
        case (op)
            OP_ADD: begin
                res_alu = sum_w[WIDTH-1:0];
                ovf_alu = sum_w[WIDTH];
            end
            OP_SUB: begin
                res_alu = diff_w[WIDTH-1:0];
                ovf_alu = diff_w[WIDTH];
            end
            OP_AND:  res_alu = ax & b;
            OP_OR:   res_alu = ax | b;
            OP_NOT:  res_alu = ~ax;
            OP_SLT:  res_alu = {{(WIDTH-1){1'b0}}, (ax < b)};
            OP_MUL:  res_alu = '0;
            OP_SHL:  res_alu = b << ax[SH_W-1:0];
            default: res_alu = '0;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    localparam logic [0:0]      S_IDLE   = 1'b0;
    localparam logic [0:0]      S_MUL    = 1'b1;
    localparam logic [SH_W-1:0] CNT_LAST = SH_W'(WIDTH - 1);

    logic [0:0]         state_q, state_d;
    logic [SH_W-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH:0]     step_sum;
    logic               mul_start;
    logic               mul_done;

    assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign load_alu  = accept && (op != OP_MUL);
    assign mul_start = accept && (op == OP_MUL);
    assign mul_done  = (state_q == S_MUL) && (cnt_q == CNT_LAST);
    assign busy      = (state_q == S_MUL);

    // Multiplier FSM: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right by one
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        step_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};
        case (state_q)
            S_IDLE: begin
                if (mul_start) begin
                    mcand_d  = ax;
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_MUL;
                end
            end
            S_MUL: begin
                acc_d    = {step_sum, acc_q[WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SH_W'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Multiplier state registers; reset aborts any multiply in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end
`else
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign load_alu = accept;
    assign busy     = 1'b0;
`endif

    // Output register next-state: hold while stalled, drop on transfer, load new results
    always_comb begin
        ans_d       = ans_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q && !out_ready;
        if (load_alu) begin
            ans_d       = res_alu;
            zero_d      = (res_alu == '0);
            ovf_d       = ovf_alu;
            out_valid_d = 1'b1;
        end
`ifdef ALU_PIPE_MUL_EN
        else if (mul_done) begin
            ans_d       = acc_d[WIDTH-1:0];
            zero_d      = (acc_d[WIDTH-1:0] == '0);
            ovf_d       = |acc_d[2*WIDTH-1:WIDTH];
            out_valid_d = 1'b1;
        end
`endif
    end

    // Output register flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ans_q       <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            ans_q       <= ans_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ans       = ans_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe (WIDTH=32, A_WIDTH=8). Expected results are pushed
// to a scoreboard queue at input acceptance and compared at output transfer;
// directed timing and boundary checks sit between the steps.
// Honours ALU_PIPE_MUL_EN the same way as the design.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ans;
    logic        zero;
    logic        ovf;
    logic        busy;

    typedef struct packed {
        logic [31:0] ans;
        logic        zero;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    logic acc_s;
    logic ready_s;

    alu_pipe #(.WIDTH(32), .A_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .ans(ans), .zero(zero), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [7:0] aa, input logic [31:0] bb, input logic [2:0] oo);
        exp_t        e;
        logic [63:0] t;
        logic [31:0] ax;
        ax    = {24'd0, aa};
        e.ans = 32'd0;
        e.ovf = 1'b0;
        t     = 64'd0;
        case (oo)
            3'd0: begin t = {32'd0, ax} + {32'd0, bb}; e.ans = t[31:0]; e.ovf = t[32]; end
            3'd1: begin e.ans = ax - bb; e.ovf = (ax < bb); end
            3'd2: e.ans = ax & bb;
            3'd3: e.ans = ax | bb;
            3'd4: e.ans = ~ax;
            3'd5: e.ans = (ax < bb) ? 32'd1 : 32'd0;
`ifdef ALU_PIPE_MUL_EN
            3'd6: begin t = {32'd0, ax} * {32'd0, bb}; e.ans = t[31:0]; e.ovf = |t[63:32]; end
`else
            3'd6: e.ans = 32'd0;
`endif
            default: e.ans = bb << aa[4:0];
        endcase
        e.zero = (e.ans == 32'd0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: sample handshakes just before the edge, then return #1 after it
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_out", {63'd0, out_valid}, 64'd0);
            end else begin
                e = q.pop_front();
                check("sb_ans", {32'd0, ans}, {32'd0, e.ans});
                check("sb_zero", {63'd0, zero}, {63'd0, e.zero});
                check("sb_ovf", {63'd0, ovf}, {63'd0, e.ovf});
            end
        end
        ready_s = in_ready;
        acc_s   = in_valid && in_ready;
        if (acc_s) q.push_back(model(a, b, op));
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] aa, input logic [31:0] bb, input logic [2:0] oo);
        a = aa; b = bb; op = oo; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (acc_s) break;
        end
        in_valid = 1'b0;
        if (!acc_s) check("accept_timeout", {63'd0, ready_s}, 64'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 60 && q.size() > 0; i++) tick();
        check("drain_empty", 64'(q.size()), 64'd0);
        check("drain_ov", {63'd0, out_valid}, 64'd0);
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, "_ans"}, {32'd0, ans}, 64'd0);
        check({tag, "_flags"}, {61'd0, zero, ovf, busy}, 64'd0);
        check({tag, "_ov"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
        acc_s = 1'b0; ready_s = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outs_zero("reset");
        rst = 1'b0;
        #1;
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);

        // Add with carry out to zero
        issue(8'hFF, 32'hFFFF_FF01, 3'b000);
        check("add_ov", {63'd0, out_valid}, 64'd1);
        check("add_ans", {32'd0, ans}, 64'd0);
        check("add_flags", {62'd0, zero, ovf}, 64'd3);
        drain();

        // Sub with borrow, then set-less-than
        issue(8'd5, 32'd7, 3'b001);
        check("sub_ans", {32'd0, ans}, 64'hFFFF_FFFE);
        check("sub_ovf", {63'd0, ovf}, 64'd1);
        issue(8'd5, 32'd7, 3'b101);
        check("slt_ans", {32'd0, ans}, 64'd1);
        check("slt_zero", {63'd0, zero}, 64'd0);
        drain();

        // Backpressure: result held, upstream stalled
        out_ready = 1'b0;
        issue(8'h0F, 32'h3C, 3'b010);
        check("bp_ans", {32'd0, ans}, 64'h0C);
        a = 8'h03; b = 32'h5; op = 3'b011; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_in_ready", {63'd0, ready_s}, 64'd0);
            check("bp_hold", {31'd0, out_valid, ans}, {31'd0, 1'b1, 32'h0C});
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_acc", {63'd0, acc_s}, 64'd1);
        // Back-to-back ops at full rate
        for (int i = 0; i < 10; i++) begin
            a  = 8'($urandom);
            b  = $urandom;
            op = 3'(i % 8);
`ifdef ALU_PIPE_MUL_EN
            if (op == 3'b110) op = 3'b111;
`endif
            tick();
            check("b2b_accept", {63'd0, acc_s}, 64'd1);
        end
        drain();

        // Shift amount wraps modulo WIDTH
        issue(8'd36, 32'd1, 3'b111);
        check("shl36_ans", {32'd0, ans}, 64'd16);
        issue(8'd31, 32'd1, 3'b111);
        check("shl31_ans", {32'd0, ans}, 64'h8000_0000);
        issue(8'd32, 32'd1, 3'b111);
        check("shl32_ans", {32'd0, ans}, 64'd1);
        issue(8'hAA, 32'h0, 3'b100);
        check("not_ans", {32'd0, ans}, 64'hFFFF_FF55);
        drain();

`ifdef ALU_PIPE_MUL_EN
        // Iterative multiply timing
        issue(8'd200, 32'd300, 3'b110);
        check("mul_busy0", {62'd0, busy, in_ready}, 64'd2);
        for (int i = 1; i < 32; i++) begin
            tick();
            check("mul_busy", {62'd0, busy, out_valid}, 64'd2);
        end
        tick();
        check("mul_done", {62'd0, busy, out_valid}, 64'd1);
        check("mul_ans", {32'd0, ans}, 64'd60000);
        check("mul_ovf", {63'd0, ovf}, 64'd0);
        drain();
        issue(8'hFF, 32'h8000_0000, 3'b110);
        for (int i = 0; i < 40 && !out_valid; i++) tick();
        check("mul2_ans", {32'd0, ans}, 64'h8000_0000);
        check("mul2_ovf", {63'd0, ovf}, 64'd1);
        drain();

        // Reset during multiply
        issue(8'd200, 32'd300, 3'b110);
        repeat (10) tick();
        rst = 1'b1;
        #1;
        check_outs_zero("mid_mul_rst");
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mul_rst_in_ready", {63'd0, in_ready}, 64'd1);
`else
        // Op 110 without the multiplier is a single-cycle zero
        issue(8'd200, 32'd300, 3'b110);
        check("mul_off_ans", {32'd0, ans}, 64'd0);
        check("mul_off_flags", {62'd0, zero, ovf}, 64'd2);
        drain();
`endif

        // Reset with a pending result: it is lost
        out_ready = 1'b0;
        issue(8'd4, 32'd4, 3'b000);
        check("pend_ans", {32'd0, ans}, 64'd8);
        rst = 1'b1;
        #1;
        check_outs_zero("pend_rst");
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        issue(8'd1, 32'd2, 3'b000);
        check("post_rst_add", {32'd0, ans}, 64'd3);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
